// File: rtl/sy_ppl_instr_realign_if.sv
// Fetch-side realigner bus: fetch-word handshake in, raw-instruction handshake out,
// plus the redirect (flush) request that travels with them.
interface sy_ppl_instr_realign_if #(
  parameter int unsigned PC_W = 64
);

  logic            flush_i;
  logic [PC_W-1:0] flush_pc_i;
  logic            fet_vld_i;
  logic            fet_rdy_o;
  logic [31:0]     fet_data_i;
  logic            fet_err_i;
  logic            ins_vld_o;
  logic            ins_rdy_i;
  logic [31:0]     ins_data_o;
  logic [PC_W-1:0] ins_pc_o;
  logic            ins_is_rvc_o;
  logic            ins_err_o;

  // Upstream/downstream agent view (drives fetch words and redirects, consumes instructions)
  modport master (
    output flush_i, flush_pc_i, fet_vld_i, fet_data_i, fet_err_i, ins_rdy_i,
    input  fet_rdy_o, ins_vld_o, ins_data_o, ins_pc_o, ins_is_rvc_o, ins_err_o
  );

  // Realigner view
  modport slave (
    input  flush_i, flush_pc_i, fet_vld_i, fet_data_i, fet_err_i, ins_rdy_i,
    output fet_rdy_o, ins_vld_o, ins_data_o, ins_pc_o, ins_is_rvc_o, ins_err_o
  );

endinterface

// File: rtl/sy_ppl_instr_realign.sv
// Instruction realigner: splits 32-bit fetch words into halfword parcels held in a
// small FIFO and reassembles 16/32-bit instructions (including ones straddling a
// word boundary), presenting one raw instruction per cycle with its PC.
// Optional feature macro: SY_RVC_EN (compressed-instruction support). When it is
// undefined every instruction is treated as 32-bit.
module sy_ppl_instr_realign #(
  parameter int unsigned PC_W     = 64,
  parameter int unsigned HW_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sy_ppl_instr_realign_if.slave bus
);

  localparam int unsigned PTR_W = (HW_DEPTH > 1) ? $clog2(HW_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(HW_DEPTH + 1);

  // Parcel storage and FIFO bookkeeping
  logic [15:0]         parcel_q [HW_DEPTH];
  logic [HW_DEPTH-1:0] perr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [PC_W-1:0]     pc_q;
  logic                drop_first_q;
  logic                err_hold_q;

  // Head view and formation results
  logic [PTR_W-1:0]    rd_ptr_nx1;
  logic [PTR_W-1:0]    wr_ptr_nx1;
  logic [15:0]         p0;
  logic [15:0]         p1;
  logic                e0;
  logic                e1;
  logic [CNT_W-1:0]    free_slots;
  logic                formable;
  logic                form_err;
  logic [31:0]         form_data;
  logic [1:0]          form_pop;
  logic [2:0]          form_pc_inc;
`ifdef SY_RVC_EN
  logic                form_rvc;
`endif

  // Handshake and flush-target signals
  logic                fet_rdy;
  logic                ins_vld;
  logic                fire_in;
  logic                fire_out;
  logic [1:0]          push_n;
  logic [1:0]          pop_n;
  logic [PC_W-1:0]     flush_tgt;
  logic                flush_drop;

  assign rd_ptr_nx1 = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_nx1 = wr_ptr_q + PTR_W'(1);
  assign p0         = parcel_q[rd_ptr_q];
  assign p1         = parcel_q[rd_ptr_nx1];
  assign e0         = perr_q[rd_ptr_q];
  assign e1         = perr_q[rd_ptr_nx1];
  assign free_slots = CNT_W'(HW_DEPTH) - count_q;

  // Redirect target; without compressed support the halfword offset is ignored
`ifdef SY_RVC_EN
  assign flush_tgt  = bus.flush_pc_i;
  assign flush_drop = bus.flush_pc_i[1];
`else
  assign flush_tgt  = bus.flush_pc_i & ~PC_W'(2);
  assign flush_drop = 1'b0;
`endif

  // Decide what instruction (if any) can be formed from the parcels at the head
  always_comb begin
    formable    = 1'b0;
    form_err    = 1'b0;
    form_data   = 32'h0;
    form_pop    = 2'd0;
    form_pc_inc = 3'd0;
`ifdef SY_RVC_EN
    form_rvc    = 1'b0;
    if (count_q >= CNT_W'(1)) begin
      if (e0) begin
        // Faulting parcel: report it as a 16-bit slot and stop
        formable    = 1'b1;
        form_rvc    = 1'b1;
        form_err    = 1'b1;
        form_pop    = 2'd1;
        form_pc_inc = 3'd2;
      end else if (p0[1:0] != 2'b11) begin
        formable    = 1'b1;
        form_rvc    = 1'b1;
        form_data   = {16'h0, p0};
        form_pop    = 2'd1;
        form_pc_inc = 3'd2;
      end else if (count_q >= CNT_W'(2)) begin
        formable    = 1'b1;
        form_err    = e1;
        form_data   = {p1, p0};
        form_pop    = 2'd2;
        form_pc_inc = 3'd4;
      end
    end
`else
    if (count_q >= CNT_W'(2)) begin
      formable    = 1'b1;
      form_pop    = 2'd2;
      form_pc_inc = 3'd4;
      if (e0) begin
        form_err  = 1'b1;
      end else begin
        form_err  = e1;
        form_data = {p1, p0};
      end
    end
`endif
  end

  // Handshake qualification and per-cycle push/pop amounts
  always_comb begin
    fet_rdy  = (free_slots >= CNT_W'(2)) & ~bus.flush_i & ~err_hold_q;
    ins_vld  = formable & ~bus.flush_i & ~err_hold_q;
    fire_in  = bus.fet_vld_i & fet_rdy;
    fire_out = ins_vld & bus.ins_rdy_i;
    push_n   = 2'd0;
    pop_n    = 2'd0;
    if (fire_in) begin
      push_n = drop_first_q ? 2'd1 : 2'd2;
    end
    if (fire_out) begin
      pop_n = form_pop;
    end
  end

  // Output drive; everything reads as zero while no instruction is presented
  always_comb begin
    bus.fet_rdy_o    = fet_rdy;
    bus.ins_vld_o    = ins_vld;
    bus.ins_data_o   = ins_vld ? form_data : 32'h0;
    bus.ins_pc_o     = ins_vld ? pc_q : '0;
    bus.ins_err_o    = ins_vld & form_err;
`ifdef SY_RVC_EN
    bus.ins_is_rvc_o = ins_vld & form_rvc;
`else
    bus.ins_is_rvc_o = 1'b0;
`endif
  end

  // Parcel writes: low then high halfword, or only the high one after a mid-word redirect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(HW_DEPTH); i++) begin
        parcel_q[i] <= 16'h0;
      end
      perr_q <= '0;
    end else if (fire_in) begin
      if (drop_first_q) begin
        parcel_q[wr_ptr_q] <= bus.fet_data_i[31:16];
        perr_q[wr_ptr_q]   <= bus.fet_err_i;
      end else begin
        parcel_q[wr_ptr_q]   <= bus.fet_data_i[15:0];
        parcel_q[wr_ptr_nx1] <= bus.fet_data_i[31:16];
        perr_q[wr_ptr_q]     <= bus.fet_err_i;
        perr_q[wr_ptr_nx1]   <= bus.fet_err_i;
      end
    end
  end

  // FIFO pointers, occupancy, PC and fault/redirect flags; flush overrides all handshakes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pc_q         <= '0;
      drop_first_q <= 1'b0;
      err_hold_q   <= 1'b0;
    end else if (bus.flush_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pc_q         <= flush_tgt;
      drop_first_q <= flush_drop;
      err_hold_q   <= 1'b0;
    end else begin
      count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      if (fire_in) begin
        wr_ptr_q     <= wr_ptr_q + PTR_W'(push_n);
        drop_first_q <= 1'b0;
      end
      if (fire_out) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
        pc_q     <= pc_q + PC_W'(form_pc_inc);
        if (form_err) begin
          err_hold_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sy_ppl_instr_realign.sv
// Self-checking bench for sy_ppl_instr_realign: table of fetch words with their
// expected instructions, scoreboard queue compared when the DUT emits, plus
// hand-written backpressure, fault/err_hold and asynchronous-reset sequences.
module tb_sy_ppl_instr_realign;

  localparam int unsigned PC_W = 64;
`ifdef SY_RVC_EN
  localparam logic RVC = 1'b1;
`else
  localparam logic RVC = 1'b0;
`endif

  typedef struct {
    logic        fl;
    logic [63:0] fpc;
    logic [31:0] word;
    int          n;
    logic [31:0] d0;
    logic [63:0] pc0;
    logic        r0;
    logic [31:0] d1;
    logic [63:0] pc1;
    logic        r1;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [63:0] pc;
    logic        r;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   due_q[$];
  exp_t mon_e;
  vec_t tbl[6];

  sy_ppl_instr_realign_if #(.PC_W(PC_W)) bus ();

  sy_ppl_instr_realign #(.PC_W(PC_W), .HW_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic [63:0] fpc, input logic [31:0] w,
                              input int n, input logic [31:0] d0, input logic [63:0] pc0,
                              input logic r0, input logic [31:0] d1, input logic [63:0] pc1,
                              input logic r1);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.word = w; v.n = n;
    v.d0 = d0; v.pc0 = pc0; v.r0 = r0;
    v.d1 = d1; v.pc1 = pc1; v.r1 = r1;
    return v;
  endfunction

  // Monitor: latency checks and scoreboard compare on every accepted instruction
  always @(negedge clk) begin
    if (!rst) begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        check("latency_vld", bus.ins_vld_o, 1);
      end
      if (bus.ins_vld_o && bus.ins_rdy_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ins: got pc 0x%0h data 0x%0h, required no output", bus.ins_pc_o, bus.ins_data_o);
        end else begin
          mon_e = sb.pop_front();
          check("ins_data", bus.ins_data_o, mon_e.d);
          check("ins_pc", bus.ins_pc_o, mon_e.pc);
          check("ins_is_rvc", bus.ins_is_rvc_o, mon_e.r);
          check("ins_err", bus.ins_err_o, mon_e.e);
        end
      end
    end
  end

  task automatic drain(input int budget);
    int i = 0;
    while (sb.size() > 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending instructions, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [63:0] pc);
    drain(50);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = pc;
    @(negedge clk);
    check("flush_fet_rdy", bus.fet_rdy_o, 0);
    check("flush_ins_vld", bus.ins_vld_o, 0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic werr, input int budget);
    exp_t x;
    bit   acc = 1'b0;
    bus.fet_vld_i  = 1'b1;
    bus.fet_data_i = v.word;
    bus.fet_err_i  = werr;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk);
      if (bus.fet_rdy_o) begin
        acc = 1'b1;
        if (v.n >= 1) begin
          x.d = v.d0; x.pc = v.pc0; x.r = v.r0; x.e = werr;
          sb.push_back(x);
          due_q.push_back(cyc + 1);
        end
        if (v.n >= 2) begin
          x.d = v.d1; x.pc = v.pc1; x.r = v.r1; x.e = werr;
          sb.push_back(x);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.fet_vld_i  = 1'b0;
    bus.fet_data_i = 32'h0;
    bus.fet_err_i  = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: word 0x%0h not accepted within %0d cycles, required accept", v.word, budget);
    end
  endtask

  // Faulting word: one error slot, then fetch and output stay blocked
  task automatic fault_seq();
    do_flush(64'h5000);
    send(mk(1'b0, 64'h0, 32'h00000013, 1, 32'h0, 64'h5000, RVC, 32'h0, 64'h0, 1'b0), 1'b1, 20);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.fet_vld_i  = 1'b1;
    bus.fet_data_i = 32'h00000013;
    repeat (4) begin
      @(negedge clk);
      check("hold_fet_rdy", bus.fet_rdy_o, 0);
      check("hold_ins_vld", bus.ins_vld_o, 0);
    end
    @(posedge clk);
    #1;
    bus.fet_vld_i  = 1'b0;
    bus.fet_data_i = 32'h0;
  endtask

  initial begin
    bus.flush_i    = 1'b0;
    bus.flush_pc_i = '0;
    bus.fet_vld_i  = 1'b0;
    bus.fet_data_i = 32'h0;
    bus.fet_err_i  = 1'b0;
    bus.ins_rdy_i  = 1'b1;

`ifdef SY_RVC_EN
    tbl[0] = mk(1'b1, 64'h1000, 32'h00000013, 1, 32'h00000013, 64'h1000, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[1] = mk(1'b0, 64'h0,    32'h00A50533, 1, 32'h00A50533, 64'h1004, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[2] = mk(1'b1, 64'h2000, 32'h45014505, 2, 32'h00004505, 64'h2000, 1'b1, 32'h00004501, 64'h2002, 1'b1);
    tbl[3] = mk(1'b1, 64'h3000, 32'h00134501, 1, 32'h00004501, 64'h3000, 1'b1, 32'h0, 64'h0, 1'b0);
    tbl[4] = mk(1'b0, 64'h0,    32'h45050000, 2, 32'h00000013, 64'h3002, 1'b0, 32'h00004505, 64'h3006, 1'b1);
    tbl[5] = mk(1'b1, 64'h4002, 32'h4505ABCD, 1, 32'h00004505, 64'h4002, 1'b1, 32'h0, 64'h0, 1'b0);
`else
    tbl[0] = mk(1'b1, 64'h1000, 32'h00000013, 1, 32'h00000013, 64'h1000, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[1] = mk(1'b0, 64'h0,    32'h00A50533, 1, 32'h00A50533, 64'h1004, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[2] = mk(1'b1, 64'h2000, 32'h45014505, 1, 32'h45014505, 64'h2000, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[3] = mk(1'b1, 64'h3000, 32'h00134501, 1, 32'h00134501, 64'h3000, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[4] = mk(1'b0, 64'h0,    32'h45050000, 1, 32'h45050000, 64'h3004, 1'b0, 32'h0, 64'h0, 1'b0);
    tbl[5] = mk(1'b1, 64'h4002, 32'h4505ABCD, 1, 32'h4505ABCD, 64'h4000, 1'b0, 32'h0, 64'h0, 1'b0);
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ins_vld", bus.ins_vld_o, 0);
    check("rst_ins_data", bus.ins_data_o, 0);
    check("rst_ins_pc", bus.ins_pc_o, 0);
    check("rst_ins_rvc", bus.ins_is_rvc_o, 0);
    check("rst_ins_err", bus.ins_err_o, 0);
    check("rst_fet_rdy", bus.fet_rdy_o, 1);
    @(posedge clk);
    #1;

    // Table-driven words, back to back unless a redirect precedes them
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].fl) do_flush(tbl[i].fpc);
      send(tbl[i], 1'b0, 20);
    end
    drain(50);

    // Backpressure: FIFO fills, fetch stalls, then everything drains in order
    do_flush(64'h6000);
    bus.ins_rdy_i = 1'b0;
    send(mk(1'b0, 64'h0, 32'h00100093, 1, 32'h00100093, 64'h6000, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    send(mk(1'b0, 64'h0, 32'h00200113, 1, 32'h00200113, 64'h6004, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    @(negedge clk);
    check("bp_full_fet_rdy", bus.fet_rdy_o, 0);
    check("bp_hold_ins_vld", bus.ins_vld_o, 1);
    check("bp_hold_ins_pc", bus.ins_pc_o, 64'h6000);
    repeat (2) begin
      @(negedge clk);
      check("bp_stall_fet_rdy", bus.fet_rdy_o, 0);
    end
    @(posedge clk);
    #1;
    bus.ins_rdy_i = 1'b1;
    @(negedge clk);
    check("bp_rdy_before_pop", bus.fet_rdy_o, 0);
    @(negedge clk);
    check("bp_rdy_after_pop", bus.fet_rdy_o, 1);
    @(posedge clk);
    #1;
    send(mk(1'b0, 64'h0, 32'h00300193, 1, 32'h00300193, 64'h6008, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    send(mk(1'b0, 64'h0, 32'h00400213, 1, 32'h00400213, 64'h600C, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    drain(50);

    // Fault, blocked until redirect, then normal operation resumes
    fault_seq();
    do_flush(64'h1000);
    send(mk(1'b0, 64'h0, 32'h00A50533, 1, 32'h00A50533, 64'h1000, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    drain(50);

    // Fault again, then asynchronous reset clears the hold immediately
    fault_seq();
    #2;
    rst = 1'b1;
    #1;
    check("arst_hold_fet_rdy", bus.fet_rdy_o, 1);
    check("arst_hold_ins_vld", bus.ins_vld_o, 0);
    sb.delete();
    due_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Buffered instruction wiped by a mid-cycle reset
    do_flush(64'h5000);
    bus.ins_rdy_i = 1'b0;
    send(mk(1'b0, 64'h0, 32'h00A50533, 0, 32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    @(negedge clk);
    check("pre_rst_ins_vld", bus.ins_vld_o, 1);
    check("pre_rst_ins_data", bus.ins_data_o, 32'h00A50533);
    check("pre_rst_ins_pc", bus.ins_pc_o, 64'h5000);
    #1;
    rst = 1'b1;
    #1;
    check("arst_ins_vld", bus.ins_vld_o, 0);
    check("arst_ins_data", bus.ins_data_o, 0);
    check("arst_ins_pc", bus.ins_pc_o, 0);
    check("arst_ins_rvc", bus.ins_is_rvc_o, 0);
    check("arst_ins_err", bus.ins_err_o, 0);
    check("arst_fet_rdy", bus.fet_rdy_o, 1);
    sb.delete();
    due_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ins_rdy_i = 1'b1;
    @(negedge clk);
    check("post_rst_ins_vld", bus.ins_vld_o, 0);
    @(posedge clk);
    #1;

    // Normal operation after reset
    do_flush(64'h1000);
    send(mk(1'b0, 64'h0, 32'h00000013, 1, 32'h00000013, 64'h1000, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    send(mk(1'b0, 64'h0, 32'h00A50533, 1, 32'h00A50533, 64'h1004, 1'b0, 32'h0, 64'h0, 1'b0), 1'b0, 20);
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sy_ppl_instr_realign.md
# sy_ppl_instr_realign

Fetch-side realigner between the instruction-fetch response path and the compressed decoder. Accepts 32-bit-aligned fetch words, splits them into 16-bit parcels in a small halfword FIFO, reassembles 16- and 32-bit instructions, including those straddling word boundaries, and presents one raw instruction per cycle with its PC. The output feeds the compressed decoder unchanged; upper 16 bits are zero for compressed instructions.

## Interface
- PC_W, 64, PC / address width
- HW_DEPTH, 4, halfword FIFO depth; power of two, ≥4

- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- flush_i  in  1  redirect; discards all buffered state
- flush_pc_i  in  PC_W  redirect target, halfword aligned
- fet_vld_i  in  1  fetch word valid
- fet_rdy_o  out  1  fetch word accepted when high with fet_vld_i
- fet_data_i  in  32  fetch word, little-endian; bits [15:0] are the lower address
- fet_err_i  in  1  fetch access fault for this word
- ins_vld_o  out  1  instruction valid
- ins_rdy_i  in  1  downstream accepts
- ins_data_o  out  32  raw instruction; {16'b0, parcel} when compressed
- ins_pc_o  out  PC_W  instruction address
- ins_is_rvc_o  out  1  instruction is 16-bit
- ins_err_o  out  1  instruction carries a fetch fault

Reset is one clock, clk_i, with rst_i asynchronous and active-high.

## Operation
- FIFO holds HW_DEPTH entries of {16-bit parcel, err}. Occupancy count is 0..HW_DEPTH. Read/write pointers wrap modulo HW_DEPTH.
- Push: on fet_vld_i & fet_rdy_o, write low then high halfword, both tagged with fet_err_i. When drop_first=1, write only the high halfword and clear drop_first.
- fet_rdy_o = (free ≥ 2) & ~flush_i & ~err_hold.
- Instruction formation at head:
  - Head err=1: emit fault, ins_err_o=1, ins_data_o=0, ins_is_rvc_o=1; pop 1 and set err_hold.
  - Head[1:0]≠2'b11: compressed. Needs count ≥1; pop 1; PC += 2.
  - Otherwise: needs count ≥2; data = {parcel1, parcel0}; ins_err_o = err of parcel1; pop 2; PC += 4.
- ins_vld_o = instruction formable & ~flush_i & ~err_hold. Outputs are undefined-but-stable (zero) when not valid.
- err_hold: set on a faulting pop. While set, no fetch is accepted and no output is produced. It is cleared only by flush_i.
- Push and pop in the same cycle are both legal; count updates by push_n − pop_n.
- Flush (highest priority): next cycle count=0, pointers=0, err_hold=0, pc=flush_pc_i, drop_first=flush_pc_i[1]. Handshakes in the flush cycle are ignored.

## Timing
- Reset values: ins_vld_o=0, ins_data_o=0, ins_pc_o=0, ins_is_rvc_o=0, ins_err_o=0, fet_rdy_o=1 after reset release (count=0). drop_first and err_hold are 0.
- Latency: word accepted in cycle N → instruction visible in cycle N+1. There is no combinational fet→ins path.
- fet_rdy_o depends only on registered state and flush_i.
- Throughput: 1 instruction/cycle; a sustained stream of 32-bit instructions with one word per cycle runs with no bubbles.
- A straddling instruction becomes valid the cycle after its second word is accepted.
- Full (count ≥ HW_DEPTH−1) drops fet_rdy_o; it rises the cycle after a pop frees ≥2 slots.
- rst_i mid-operation: state clears asynchronously; outputs go to reset values immediately.

## Configuration
- SY_RVC_EN defined: behaviour as above.
- SY_RVC_EN undefined: every instruction is 32-bit.
  - ins_is_rvc_o is tied to 0.
  - drop_first is never set; flush_pc_i[1] is ignored and treated as 0.
  - Pop is always 2 and PC += 4.
  - A head parcel with [1:0]≠11 is still emitted as a 32-bit instruction; illegality is left to the decoder.

## Test plan
- Flush to 0x1000, then words 0x00000013, 0x00A50533 → two instructions at 0x1000 and 0x1004, is_rvc=0, one per cycle starting 1 cycle after the first accept.
- Flush to 0x2000, word 0x45014505 → c.li parcels 0x4505 at 0x2000 and 0x4501 at 0x2002. ins_data_o=0x00004505, then 0x00004501, is_rvc=1.
- Straddle from 0x3000: words 0x00134501, then 0x45050000 → 0x4501 at 0x3000, then 0x00000013 at 0x3002 (valid after the second word), then 0x4505 at 0x3006.
- Flush to 0x4002, word 0x4505ABCD → 0xABCD dropped; single compressed 0x4505 at 0x4002.
- ins_rdy_i held 0 while fetch streams 32-bit instructions → fet_rdy_o falls when count ≥3. No data is lost; all instructions come out in order after ins_rdy_i=1.
- Word at 0x5000 with fet_err_i=1 → one output at 0x5000 with ins_err_o=1, ins_data_o=0. Afterwards fet_rdy_o=0 and ins_vld_o=0 until flush_i; post-flush operation is normal. Repeat the sequence with rst_i asserted mid-stream → all outputs zero immediately.
